// File: rtl/graphics_pkg.sv
// Shared types for the graphics front end: triangle scheduler states, frame
// statistics and the retire bookkeeping helper.
package graphics_pkg;

  localparam int P_WIDTH_DEF    = 16;
  localparam int TRI_WORD_WIDTH = 9 * P_WIDTH_DEF;
  localparam int STAT_WIDTH     = 16;

  typedef enum logic [2:0] {
    TS_IDLE     = 3'd0,
    TS_FETCH    = 3'd1,
    TS_WAIT_MEM = 3'd2,
    TS_ISSUE    = 3'd3,
    TS_WAIT_RES = 3'd4,
    TS_DONE     = 3'd5
  } tri_sched_state_t;

  typedef enum logic [1:0] {
    RK_NONE    = 2'd0,
    RK_DRAWN   = 2'd1,
    RK_CULLED  = 2'd2,
    RK_TIMEOUT = 2'd3
  } retire_kind_t;

  typedef struct packed {
    logic [STAT_WIDTH-1:0] drawn;
    logic [STAT_WIDTH-1:0] culled;
    logic [STAT_WIDTH-1:0] timeouts;
  } tri_stats_t;

  localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1'b1);

  // Bumps exactly one frame counter according to how a triangle left the pipe.
  function automatic tri_stats_t stats_retire(input tri_stats_t s, input retire_kind_t kind);
    tri_stats_t r;
    r = s;
    case (kind)
      RK_DRAWN:   r.drawn    = s.drawn + STAT_ONE;
      RK_CULLED:  r.culled   = s.culled + STAT_ONE;
      RK_TIMEOUT: r.timeouts = s.timeouts + STAT_ONE;
      default:    r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tri_pre_proc_scheduler.sv
// Frame sequencer for vertex_pre_proc: walks the triangle BRAM, issues one
// triangle at a time, tags results with their index and keeps frame stats.
module tri_pre_proc_scheduler
  import graphics_pkg::*;
#(
  parameter int P_WIDTH        = P_WIDTH_DEF,
  parameter int C_WIDTH        = 18,
  parameter int V_WIDTH        = 16,
  parameter int TRI_ADDR_WIDTH = 12,
  parameter int MEM_LATENCY    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      frame_start_in,
  input  logic [TRI_ADDR_WIDTH-1:0] num_tris_in,
  input  logic [3*C_WIDTH-1:0]      cam_C_in,
  input  logic [3*V_WIDTH-1:0]      cam_u_in,
  input  logic [3*V_WIDTH-1:0]      cam_v_in,
  input  logic [3*V_WIDTH-1:0]      cam_n_in,
  output logic                      mem_en_out,
  output logic [TRI_ADDR_WIDTH-1:0] mem_addr_out,
  input  logic [9*P_WIDTH-1:0]      mem_data_in,
  output logic                      pp_valid_out,
  input  logic                      pp_ready_in,
  output logic [9*P_WIDTH-1:0]      pp_P_out,
  output logic [3*C_WIDTH-1:0]      pp_C_out,
  output logic [3*V_WIDTH-1:0]      pp_u_out,
  output logic [3*V_WIDTH-1:0]      pp_v_out,
  output logic [3*V_WIDTH-1:0]      pp_n_out,
  output logic                      pp_ready_out,
  input  logic                      pp_valid_in,
  input  logic                      pp_short_circuit_in,
  input  logic                      ds_ready_in,
  output logic                      ds_valid_out,
  output logic [TRI_ADDR_WIDTH-1:0] ds_tri_id_out,
  output logic                      busy_out,
  output logic                      frame_done_out,
  output logic [TRI_ADDR_WIDTH-1:0] drawn_count_out,
  output logic [TRI_ADDR_WIDTH-1:0] culled_count_out,
  output logic [TRI_ADDR_WIDTH-1:0] timeout_count_out
);

  localparam int TRI_W = 9 * P_WIDTH;
  localparam int LAT_W = $clog2(MEM_LATENCY + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [LAT_W-1:0]          LAT_LAST = LAT_W'(MEM_LATENCY - 1);
  localparam logic [LAT_W-1:0]          LAT_ONE  = LAT_W'(1'b1);
  localparam logic [TMR_W-1:0]          TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]          TMR_ONE  = TMR_W'(1'b1);
  localparam logic [TRI_ADDR_WIDTH-1:0] IDX_ONE  = TRI_ADDR_WIDTH'(1'b1);

  tri_sched_state_t            state_q, state_d;
  logic [TRI_ADDR_WIDTH-1:0]   tri_idx_q, tri_idx_d;
  logic [TRI_ADDR_WIDTH-1:0]   num_tris_q, num_tris_d;
  logic [LAT_W-1:0]            lat_cnt_q, lat_cnt_d;
  logic [TMR_W-1:0]            timer_q, timer_d;
  logic [TRI_W-1:0]            p_q, p_d;
  logic [3*C_WIDTH-1:0]        cam_c_q, cam_c_d;
  logic [3*V_WIDTH-1:0]        cam_u_q, cam_u_d;
  logic [3*V_WIDTH-1:0]        cam_v_q, cam_v_d;
  logic [3*V_WIDTH-1:0]        cam_n_q, cam_n_d;
  tri_stats_t                  stats_q, stats_d;
  retire_kind_t                retire_kind;

  // Next-state and datapath updates for the frame walk.
  always_comb begin
    state_d     = state_q;
    tri_idx_d   = tri_idx_q;
    num_tris_d  = num_tris_q;
    lat_cnt_d   = lat_cnt_q;
    timer_d     = timer_q;
    p_d         = p_q;
    cam_c_d     = cam_c_q;
    cam_u_d     = cam_u_q;
    cam_v_d     = cam_v_q;
    cam_n_d     = cam_n_q;
    stats_d     = stats_q;
    retire_kind = RK_NONE;

    case (state_q)
      TS_IDLE: begin
        if (frame_start_in) begin
          num_tris_d = num_tris_in;
          cam_c_d    = cam_C_in;
          cam_u_d    = cam_u_in;
          cam_v_d    = cam_v_in;
          cam_n_d    = cam_n_in;
          tri_idx_d  = '0;
          stats_d    = '0;
          state_d    = (num_tris_in == '0) ? TS_DONE : TS_FETCH;
        end else begin
          state_d = TS_IDLE;
        end
      end
      TS_FETCH: begin
        lat_cnt_d = '0;
        state_d   = TS_WAIT_MEM;
      end
      TS_WAIT_MEM: begin
        // The last counted cycle is the one where the BRAM word is valid.
        if (lat_cnt_q == LAT_LAST) begin
          p_d     = mem_data_in;
          state_d = TS_ISSUE;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_ONE;
        end
      end
      TS_ISSUE: begin
        if (pp_ready_in) begin
          timer_d = '0;
          state_d = TS_WAIT_RES;
        end else begin
          state_d = TS_ISSUE;
        end
      end
      TS_WAIT_RES: begin
        if (pp_short_circuit_in) begin
          retire_kind = RK_CULLED;
        end else if (pp_valid_in && ds_ready_in) begin
          retire_kind = RK_DRAWN;
        end else if (pp_valid_in) begin
          timer_d = timer_q;
        end else if (timer_q == TMR_LAST) begin
          retire_kind = RK_TIMEOUT;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end

        stats_d = stats_retire(stats_q, retire_kind);
        if (retire_kind == RK_NONE) begin
          state_d = TS_WAIT_RES;
        end else if (tri_idx_q == num_tris_q - IDX_ONE) begin
          state_d = TS_DONE;
        end else begin
          tri_idx_d = tri_idx_q + IDX_ONE;
          state_d   = TS_FETCH;
        end
      end
      TS_DONE: begin
        state_d = TS_IDLE;
      end
      default: begin
        state_d = TS_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= TS_IDLE;
      tri_idx_q  <= '0;
      num_tris_q <= '0;
      lat_cnt_q  <= '0;
      timer_q    <= '0;
      p_q        <= '0;
      cam_c_q    <= '0;
      cam_u_q    <= '0;
      cam_v_q    <= '0;
      cam_n_q    <= '0;
      stats_q    <= '0;
    end else begin
      state_q    <= state_d;
      tri_idx_q  <= tri_idx_d;
      num_tris_q <= num_tris_d;
      lat_cnt_q  <= lat_cnt_d;
      timer_q    <= timer_d;
      p_q        <= p_d;
      cam_c_q    <= cam_c_d;
      cam_u_q    <= cam_u_d;
      cam_v_q    <= cam_v_d;
      cam_n_q    <= cam_n_d;
      stats_q    <= stats_d;
    end
  end

  // Control outputs are decodes of the state register only.
  assign mem_en_out     = (state_q == TS_FETCH);
  assign mem_addr_out   = tri_idx_q;
  assign pp_valid_out   = (state_q == TS_ISSUE);
  assign busy_out       = (state_q != TS_IDLE);
  assign frame_done_out = (state_q == TS_DONE);
  assign ds_tri_id_out  = tri_idx_q;

  assign pp_P_out = p_q;
  assign pp_C_out = cam_c_q;
  assign pp_u_out = cam_u_q;
  assign pp_v_out = cam_v_q;
  assign pp_n_out = cam_n_q;

  // The only combinational paths from inputs to outputs.
  assign pp_ready_out = ds_ready_in;
  assign ds_valid_out = (state_q == TS_WAIT_RES) && pp_valid_in && !pp_short_circuit_in;

  assign drawn_count_out   = TRI_ADDR_WIDTH'(stats_q.drawn);
  assign culled_count_out  = TRI_ADDR_WIDTH'(stats_q.culled);
  assign timeout_count_out = TRI_ADDR_WIDTH'(stats_q.timeouts);

endmodule
